noc_output_port: RTL



---
 rtl/noc_output_port_pkg.sv | 21 ++
 rtl/noc_output_port_chk.sv | 22 ++
 rtl/noc_output_port_rr_pick.sv | 70 +++++++
 rtl/noc_output_port.sv | 139 +++++++++++++
 4 files changed

// File: rtl/noc_output_port_pkg.sv
// Shared router constants: direction indices and default link geometry.
// The input side of the router uses the same encoding.
package noc_output_port_pkg;

  localparam int NORTH          = 0;
  localparam int SOUTH          = 1;
  localparam int EAST           = 2;
  localparam int WEST           = 3;
  localparam int LOCAL          = 4;
  localparam int NOC_DATA_WIDTH = 32;
  localparam int NOC_NUM_DIRS   = 5;

  typedef enum logic [2:0] {
    DIR_NORTH = 3'd0,
    DIR_SOUTH = 3'd1,
    DIR_EAST  = 3'd2,
    DIR_WEST  = 3'd3,
    DIR_LOCAL = 3'd4
  } noc_dir_e;

endpackage

// File: rtl/noc_output_port_chk.sv
// Structural invariants of the output queue and arbiter.
module noc_output_port_chk #(
  parameter int NUM_INPUTS = 5
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  push,
  input logic                  pop,
  input logic [1:0]            count,
  input logic [NUM_INPUTS-1:0] grant
);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (count == 2'd2)));

  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= 2'd2);

  a_grant_onehot: assert property (@(posedge clk) disable iff (rst)
    $onehot0(grant));

endmodule

// File: rtl/noc_output_port_rr_pick.sv
// Rotate-priority picker: one-hot grant searching from a registered pointer.
// The pointer moves past the winner only when the grant is actually taken.
module noc_output_port_rr_pick #(
  parameter int NUM_INPUTS = 5,
  parameter int PTR_W      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_INPUTS-1:0] req,
  input  logic                  advance,
  output logic [NUM_INPUTS-1:0] grant
);

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] base_s;
  logic [PTR_W-1:0] gidx_s;
  logic [PTR_W:0]   sum_s;
  logic             found_s;

  // An out-of-range pointer is treated as index 0.
  always_comb begin
    grant   = '0;
    gidx_s  = '0;
    found_s = 1'b0;
    sum_s   = '0;
    if ({1'b0, ptr_q} >= (PTR_W+1)'(NUM_INPUTS)) begin
      base_s = '0;
    end else begin
      base_s = ptr_q;
    end
    for (int k = 0; k < NUM_INPUTS; k++) begin
      sum_s = {1'b0, base_s} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(NUM_INPUTS)) begin
        sum_s = sum_s - (PTR_W+1)'(NUM_INPUTS);
      end else begin
        sum_s = sum_s;
      end
      if (!found_s && req[sum_s[PTR_W-1:0]]) begin
        found_s                  = 1'b1;
        gidx_s                   = sum_s[PTR_W-1:0];
        grant[sum_s[PTR_W-1:0]]  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found_s) begin
      if (gidx_s == PTR_W'(NUM_INPUTS - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = gidx_s + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// Router output direction: round-robin over five inputs into a 2-entry queue.
// Define NOC_OUTPUT_PORT_STATS_EN to add pkt_count/stall_count ports.
module noc_output_port
  import noc_output_port_pkg::*;
#(
  parameter int NUM_INPUTS = NOC_NUM_DIRS,
  parameter int DATA_WIDTH = NOC_DATA_WIDTH,
  parameter int PTR_W      = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_INPUTS-1:0]            in_valid,
  output logic [NUM_INPUTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]            out_packet,
  output logic                             out_valid,
  input  logic                             out_ready
`ifdef NOC_OUTPUT_PORT_STATS_EN
  ,
  output logic [31:0]                      pkt_count,
  output logic [31:0]                      stall_count
`endif
);

  logic [DATA_WIDTH-1:0] mem_q [2];
  logic                  wr_q;
  logic                  wr_d;
  logic                  rd_q;
  logic                  rd_d;
  logic [1:0]            count_q;
  logic [1:0]            count_d;
  logic [NUM_INPUTS-1:0] grant_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_eff_s;
  logic [DATA_WIDTH-1:0] push_data_s;

  noc_output_port_rr_pick #(
    .NUM_INPUTS (NUM_INPUTS),
    .PTR_W      (PTR_W)
  ) u_pick (
    .clk     (clk),
    .rst     (rst),
    .req     (in_valid),
    .advance (push_s),
    .grant   (grant_s)
  );

  assign out_valid  = (count_q != 2'd0);
  assign out_packet = out_valid ? mem_q[rd_q] : '0;

  // A same-cycle pop frees a slot; rst gates in_ready so no handshake happens mid-reset.
  always_comb begin
    pop_s      = out_valid && out_ready;
    full_eff_s = (count_q == 2'd2) && !pop_s;
    if (rst) begin
      in_ready = '0;
    end else begin
      in_ready = grant_s & {NUM_INPUTS{~full_eff_s}};
    end
    push_s      = |in_ready;
    push_data_s = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant_s[i]) begin
        push_data_s = push_data_s | in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        push_data_s = push_data_s;
      end
    end
    wr_d = push_s ? ~wr_q : wr_q;
    rd_d = pop_s  ? ~rd_q : rd_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      count_q <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push_s) begin
        mem_q[wr_q] <= push_data_s;
      end
    end
  end

`ifdef NOC_OUTPUT_PORT_STATS_EN
  logic [31:0] pkt_count_q;
  logic [31:0] pkt_count_d;
  logic [31:0] stall_count_q;
  logic [31:0] stall_count_d;

  // Packet count wraps; stall count sticks at all-ones.
  always_comb begin
    pkt_count_d   = pop_s ? pkt_count_q + 32'd1 : pkt_count_q;
    stall_count_d = stall_count_q;
    if (out_valid && !out_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_count_q   <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign pkt_count   = pkt_count_q;
  assign stall_count = stall_count_q;
`endif

  noc_output_port_chk #(
    .NUM_INPUTS (NUM_INPUTS)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .count (count_q),
    .grant (grant_s)
  );

endmodule
